bnn_weight_streamer: RTL

Transmit-side driver for the BNN weight-load interface. It buffers one full bank of per-neuron weight words from an upstream writer. On `start`, it replays the bank to the BNN core as a burst: first a one-cycle `tgt_clear` pulse that realigns the core's load pointer, then one `load_en` beat per neuron with a programmable idle gap between beats. It sits between the host/config path and the core's `load_en` / 6-bit weight pins.

---
 rtl/bnn_weight_streamer_if.sv | 11 +
 rtl/bnn_weight_streamer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bnn_weight_streamer_if.sv
// Upstream write channel into the weight bank: valid/ready handshake carrying one weight word.
interface bnn_weight_streamer_if #(
  parameter int WEIGHT_W = 6
);
  logic                wr_valid;
  logic                wr_ready;
  logic [WEIGHT_W-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/bnn_weight_streamer.sv
// Weight-bank buffer and burst replayer for the BNN core load port.
// A full bank is replayed as: one tgt_clear pulse, then one load_en beat per
// neuron separated by gap_q idle cycles, then a one-cycle done pulse.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_W    = 6,
  parameter int GAP_W       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  bnn_weight_streamer_if.slave               wr_if,
  input  logic                               i_flush,
  input  logic                               i_start,
  input  logic [GAP_W-1:0]                   i_gap,
  output logic                               o_tgt_clear,
  output logic                               o_load_en,
  output logic [WEIGHT_W-1:0]                o_weight_out,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_bank_full,
  output logic [$clog2(NUM_NEURONS+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int PTR_W = $clog2(NUM_NEURONS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [GAP_W-1:0]    r_gap_q;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [WEIGHT_W-1:0] r_bank [NUM_NEURONS];

  logic w_idle;
  logic w_bank_full;
  logic w_wr_ready;
  logic w_wr_fire;
  logic w_start_ok;
  logic w_last;

  // Flush dominates both writes and start; bank_full is the pre-edge value,
  // so a start coinciding with the filling write is not accepted.
  assign w_idle      = (r_state == S_IDLE);
  assign w_bank_full = (r_wr_ptr == CNT_W'(NUM_NEURONS));
  assign w_wr_ready  = w_idle && !w_bank_full && !i_flush;
  assign w_wr_fire   = wr_if.wr_valid && w_wr_ready;
  assign w_start_ok  = w_idle && w_bank_full && !i_flush && i_start;
  assign w_last      = (r_rd_ptr == PTR_W'(NUM_NEURONS - 1));

  assign wr_if.wr_ready = w_wr_ready;
  assign o_bank_full    = w_bank_full;
  assign o_count        = r_wr_ptr;

  // Bank storage: cleared on reset, written at wr_ptr on an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_bank[i] <= '0;
    end else if (w_wr_fire) begin
      r_bank[r_wr_ptr[PTR_W-1:0]] <= wr_if.wr_data;
    end
  end

  // Write pointer: flush rewinds it without touching bank contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_idle && i_flush) begin
      r_wr_ptr <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + CNT_W'(1);
    end
  end

  // Burst bookkeeping: read pointer, latched gap and inter-beat gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_gap_q   <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_rd_ptr <= '0;
            r_gap_q  <= i_gap;
          end
        end
        S_SEND: begin
          if (!w_last) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_gap_cnt <= r_gap_q;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_CLEAR;
      S_CLEAR: w_next_state = S_SEND;
      S_SEND: begin
        if (w_last)                w_next_state = S_DONE;
        else if (r_gap_q != '0)    w_next_state = S_GAP;
        else                       w_next_state = S_SEND;
      end
      S_GAP:   if (r_gap_cnt == GAP_W'(1)) w_next_state = S_SEND;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the registered state; weight_out is zero off-beat.
  always_comb begin
    o_tgt_clear  = 1'b0;
    o_load_en    = 1'b0;
    o_weight_out = '0;
    o_done       = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_CLEAR: o_tgt_clear = 1'b1;
      S_SEND: begin
        o_load_en    = 1'b1;
        o_weight_out = r_bank[r_rd_ptr];
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule
